mdu_core: RTL and testbench
===========================

// Module: mdu_core
// PURPOSE
//  Multiply/divide unit in the E stage of the P7 pipeline. Executes the
//  mult/div/mthi/mtlo commands issued by the decoder (start, mlu_op) and owns
//  the HI/LO registers. Returns HI/LO on res when mfhi/mflo selects them
//  (mlu_out). Drives busy to the hazard unit and honours exception/interrupt
//  cancellation (req).
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd family); >=1
//  DIV_CYCLES   10  busy cycles for div/divu; >=1
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   synchronous, active-high
//  start    in   1   decoder start (E-stage cal_mt instruction)
//  mlu_op   in   5   1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7-10 madd family; 0 none
//  mlu_out  in   3   1 read HI, 2 read LO, else none
//  rs_val   in   32  forwarded rs operand
//  rt_val   in   32  forwarded rt operand
//  req      in   1   exception/interrupt taken this cycle: cancel E-stage start
//  busy     out  1   registered; operation in flight
//  res      out  32  combinational: HI if mlu_out==1, LO if 2, else 0
// BEHAVIOUR
//  Reset: HI=0, LO=0, busy=0, state=IDLE, counter=0, pending results=0.
//  Accept: start & !req & state==IDLE. start & req: ignored, no state change.
//   start while BUSY: ignored (hazard unit stalls on start|busy); bench asserts never.
//  mthi/mtlo: HI/LO <= rs_val at the accepting edge; busy stays 0; no state change.
//  mult/multu/div/divu: at the accepting edge, compute result into pending_hi/lo,
//   counter <= N-1 (N = MULT_CYCLES or DIV_CYCLES), busy<=1, state BUSY.
//  FSM IDLE->BUSY on accept; BUSY: counter decrements each edge; at the edge
//   where counter==0: HI/LO <= pending, busy<=0, state IDLE.
//   busy is high exactly N cycles; new HI/LO is visible on res the cycle busy falls.
//  res during BUSY returns old HI/LO (hazard unit stalls mfhi/mflo on start|busy).
//  req while BUSY: no effect; the operation is committed and completes.
//  mult: signed 32x32->64, {HI,LO}=product. multu: unsigned.
//  div: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
//   0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. divu: unsigned.
//  Divisor 0 (div/divu): full DIV_CYCLES busy; HI/LO unchanged at commit.
//  mlu_op 0 or unlisted code with start: ignored.
//  reset mid-operation: aborts; all state returns to reset values, pending discarded.
// CONFIGURATION
//  MDU_MADD_EN defined: ops 7 madd, 8 maddu, 9 msub, 10 msubu accepted;
//   {HI,LO} +/- (rs*rt) (signed 7/9, unsigned 8/10), mod 2^64; latency
//   MULT_CYCLES; accumulator operand is {HI,LO} sampled at the accepting edge.
//  MDU_MADD_EN undefined: ops 7-10 treated as unlisted (ignored, busy stays 0).
// TESTING
//  mult rs=0xFFFFFFFF rt=2 -> busy high 5 cycles; then HI=0xFFFFFFFF LO=0xFFFFFFFE.
//  multu same operands -> HI=0x00000001 LO=0xFFFFFFFE after 5 cycles.
//  div rs=0xFFFFFFF9(-7) rt=2 -> busy 10 cycles; LO=0xFFFFFFFD HI=0xFFFFFFFF;
//   div by 0 with HI=0x11,LO=0x22 -> unchanged after 10 cycles.
//  mthi rs=0x1234 then mflo/mfhi -> res=0x1234 next cycle with mlu_out=1; busy stays 0.
//  start=1 req=1 op=div -> busy stays 0, HI/LO unchanged; reset at busy cycle 4
//   of a div -> busy=0, HI=LO=0 next cycle, no later commit.
//  MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, maddu rs=1 rt=1 -> HI=1 LO=0 after 5 cycles.

Source files
------------

// File: rtl/mdu_core.sv
// mdu_core: multiply/divide unit for the E stage. Owns HI/LO, runs
// mult/multu/div/divu with fixed multi-cycle latency, and handles mthi/mtlo
// in a single cycle. The result is computed at the accepting edge and held
// in pending registers. It is committed to HI/LO when the busy countdown
// expires.
// Optional feature: define MDU_MADD_EN to accept madd/maddu/msub/msubu
// (ops 7-10). When it is undefined, those codes are ignored.
//
// Handshake: the decoder issues one command by holding start high for a
// cycle. The command is accepted only if req is low and the unit is idle.
// busy is high from the edge after acceptance until the commit edge. While
// start or busy is high, the hazard unit must stall. The unit never queues
// a command: a start that arrives while busy is dropped.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  mlu_op,
  input  logic [2:0]  mlu_out,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        busy,
  output logic [31:0] res,
  output logic        state_dbg
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTHI  = 5'd5;
  localparam logic [4:0] OP_MTLO  = 5'd6;
`ifdef MDU_MADD_EN
  localparam logic [4:0] OP_MADD  = 5'd7;
  localparam logic [4:0] OP_MADDU = 5'd8;
  localparam logic [4:0] OP_MSUB  = 5'd9;
  localparam logic [4:0] OP_MSUBU = 5'd10;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t         state;
  logic [31:0]    hi, lo, pend_hi, pend_lo;
  logic [CW-1:0]  cnt;

  logic           accept, is_long;
  logic [63:0]    rs_sx, rt_sx, prod_s, prod_u, next_pend;
  logic [31:0]    rt_safe;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]    quo_u, rem_u;
  logic [CW-1:0]  load_cnt;

  // HI/LO read mux for mfhi/mflo
  always_comb begin
    res = 32'd0;
    if (mlu_out == 3'd1)      res = hi;
    else if (mlu_out == 3'd2) res = lo;
  end

  assign state_dbg = (state == S_BUSY);

  // Operation decode and one-shot result computation at the accepting edge
  always_comb begin
    accept  = start && !req && (state == S_IDLE);
    rs_sx   = {{32{rs_val[31]}}, rs_val};
    rt_sx   = {{32{rt_val[31]}}, rt_val};
    // Low 64 bits of the sign-extended product equal the signed product
    prod_s  = rs_sx * rt_sx;
    prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
    // Divisor 0 leaves HI/LO untouched, so the divider only needs a safe value
    rt_safe = (rt_val == 32'd0) ? 32'd1 : rt_val;
    if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
      quo_s = $signed(rs_val);
      rem_s = 32'sd0;
    end else begin
      quo_s = $signed(rs_val) / $signed(rt_safe);
      rem_s = $signed(rs_val) % $signed(rt_safe);
    end
    quo_u     = rs_val / rt_safe;
    rem_u     = rs_val % rt_safe;
    is_long   = 1'b0;
    next_pend = {hi, lo};
    load_cnt  = '0;
    if (accept) begin
      case (mlu_op)
        OP_MULT: begin
          is_long = 1'b1; next_pend = prod_s; load_cnt = CW'(MULT_CYCLES - 1);
        end
        OP_MULTU: begin
          is_long = 1'b1; next_pend = prod_u; load_cnt = CW'(MULT_CYCLES - 1);
        end
        OP_DIV: begin
          is_long = 1'b1; load_cnt = CW'(DIV_CYCLES - 1);
          if (rt_val != 32'd0) next_pend = {rem_s, quo_s};
        end
        OP_DIVU: begin
          is_long = 1'b1; load_cnt = CW'(DIV_CYCLES - 1);
          if (rt_val != 32'd0) next_pend = {rem_u, quo_u};
        end
`ifdef MDU_MADD_EN
        OP_MADD: begin
          is_long = 1'b1; next_pend = {hi, lo} + prod_s; load_cnt = CW'(MULT_CYCLES - 1);
        end
        OP_MADDU: begin
          is_long = 1'b1; next_pend = {hi, lo} + prod_u; load_cnt = CW'(MULT_CYCLES - 1);
        end
        OP_MSUB: begin
          is_long = 1'b1; next_pend = {hi, lo} - prod_s; load_cnt = CW'(MULT_CYCLES - 1);
        end
        OP_MSUBU: begin
          is_long = 1'b1; next_pend = {hi, lo} - prod_u; load_cnt = CW'(MULT_CYCLES - 1);
        end
`endif
        default: ;
      endcase
    end
  end

  // Control FSM: accept, count down the fixed latency, commit pending to HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && mlu_op == OP_MTHI) hi <= rs_val;
          if (accept && mlu_op == OP_MTLO) lo <= rs_val;
          if (is_long) begin
            pend_hi <= next_pend[63:32];
            pend_lo <= next_pend[31:0];
            cnt     <= load_cnt;
            busy    <= 1'b1;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_core.sv
// Bench for mdu_core: a fixed vector table, hand-written corner sequences
// (req cancel, req while busy, reset mid-divide), and random commands
// checked against an arithmetic reference model.
module tb_mdu_core;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, req, busy, state_dbg;
  logic [4:0]  mlu_op;
  logic [2:0]  mlu_out;
  logic [31:0] rs_val, rt_val, res;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;

  mdu_core #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .mlu_op(mlu_op), .mlu_out(mlu_out),
    .rs_val(rs_val), .rt_val(rt_val), .req(req), .busy(busy), .res(res),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the command semantics
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    longint          sa, sb, ma, mb, q, r, p;
    longint unsigned ua, ub, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    case (op)
      5'd1: begin p = sa * sb; {m_hi, m_lo} = p; cyc = MULT_N; end
      5'd2: begin acc = ua * ub; {m_hi, m_lo} = acc; cyc = MULT_N; end
      5'd3: begin
        cyc = DIV_N;
        if (b != 0) begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb;
          r = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      5'd4: begin
        cyc = DIV_N;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      5'd5: m_hi = a;
      5'd6: m_lo = a;
`ifdef MDU_MADD_EN
      5'd7, 5'd8, 5'd9, 5'd10: begin
        acc = {m_hi, m_lo};
        if (op == 5'd7 || op == 5'd9) p = sa * sb;
        else p = longint'(ua * ub);
        if (op <= 5'd8) acc = acc + longint'(p);
        else acc = acc - longint'(p);
        {m_hi, m_lo} = acc;
        cyc = MULT_N;
      end
`endif
      default: ;
    endcase
  endtask

  // Driver: present one command for one cycle, then count busy cycles
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq, output int cyc);
    @(negedge clk);
    start = 1'b1; mlu_op = op; rs_val = a; rt_val = b; req = rq;
    @(negedge clk);
    start = 1'b0; mlu_op = 5'd0; req = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    mlu_out = 3'd1; #1 h = res;
    mlu_out = 3'd2; #1 l = res;
    mlu_out = 3'd0; #1;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    int c;
    issue(5'd5, h, 32'd0, 1'b0, c);
    issue(5'd6, l, 32'd0, 1'b0, c);
    model(5'd5, h, 32'd0, c);
    model(5'd6, l, 32'd0, c);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] rs, rt, init_hi, init_lo, exp_hi, exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [4:0] op, logic [31:0] rs, logic [31:0] rt,
                              logic [31:0] ih, logic [31:0] il, logic [31:0] eh,
                              logic [31:0] el, int ec);
    vec_t v;
    v.name = n; v.op = op; v.rs = rs; v.rt = rt; v.init_hi = ih; v.init_lo = il;
    v.exp_hi = eh; v.exp_lo = el; v.exp_cyc = ec;
    return v;
  endfunction

  initial begin
    logic [31:0] h, l, a, b;
    logic [4:0]  op;
    int          cyc, mc;

    reset = 1'b1; start = 1'b0; req = 1'b0; mlu_op = 5'd0; mlu_out = 3'd0;
    rs_val = 32'd0; rt_val = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;

    vecs.push_back(mk("mult_neg1x2", 5'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0,
                      32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N));
    vecs.push_back(mk("multu_max_x2", 5'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0,
                      32'h0000_0001, 32'hFFFF_FFFE, MULT_N));
    vecs.push_back(mk("div_m7_2", 5'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N));
    vecs.push_back(mk("div_ovf", 5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd6,
                      32'h0000_0000, 32'h8000_0000, DIV_N));
    vecs.push_back(mk("div_by0", 5'd3, 32'd77, 32'd0, 32'h11, 32'h22,
                      32'h11, 32'h22, DIV_N));
    vecs.push_back(mk("divu_by0", 5'd4, 32'd77, 32'd0, 32'h33, 32'h44,
                      32'h33, 32'h44, DIV_N));
    vecs.push_back(mk("divu_100_7", 5'd4, 32'd100, 32'd7, 32'd0, 32'd0,
                      32'd2, 32'd14, DIV_N));
    vecs.push_back(mk("div_7_m2", 5'd3, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0,
                      32'd1, 32'hFFFF_FFFD, DIV_N));
    vecs.push_back(mk("mthi", 5'd5, 32'h1234, 32'd0, 32'd9, 32'd8,
                      32'h1234, 32'd8, 0));
    vecs.push_back(mk("op0_ignored", 5'd0, 32'd3, 32'd4, 32'h55, 32'h66,
                      32'h55, 32'h66, 0));
    vecs.push_back(mk("op11_ignored", 5'd11, 32'd3, 32'd4, 32'h55, 32'h66,
                      32'h55, 32'h66, 0));
`ifdef MDU_MADD_EN
    vecs.push_back(mk("maddu_carry", 5'd8, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
                      32'd1, 32'd0, MULT_N));
    vecs.push_back(mk("msub", 5'd9, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0,
                      32'd0, 32'd3, MULT_N));
`else
    vecs.push_back(mk("op7_ignored", 5'd7, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
                      32'd0, 32'hFFFF_FFFF, 0));
    vecs.push_back(mk("op8_ignored", 5'd8, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
                      32'd0, 32'hFFFF_FFFF, 0));
`endif

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_state", state_dbg, 0);
    read_hilo(h, l);
    chk("reset_hi", h, 0);
    chk("reset_lo", l, 0);

    // table-driven vectors
    foreach (vecs[i]) begin
      set_hilo(vecs[i].init_hi, vecs[i].init_lo);
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, cyc);
      read_hilo(h, l);
      chk({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cyc);
      chk({vecs[i].name, "_hi"}, h, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, l, vecs[i].exp_lo);
    end

    // res is zero for non-select codes
    mlu_out = 3'd3; #1 chk("res_sel3", res, 0);
    mlu_out = 3'd0; #1 chk("res_sel0", res, 0);

    // start with req: cancelled
    set_hilo(32'hA1, 32'hB2);
    issue(5'd3, 32'd100, 32'd7, 1'b1, cyc);
    chk("req_cancel_busy", busy, 0);
    repeat (12) @(negedge clk);
    read_hilo(h, l);
    chk("req_cancel_hi", h, 32'hA1);
    chk("req_cancel_lo", l, 32'hB2);

    // req while busy has no effect; old values visible during busy
    set_hilo(32'hAAAA, 32'h5555);
    @(negedge clk);
    start = 1'b1; mlu_op = 5'd2; rs_val = 32'd6; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; mlu_op = 5'd0; req = 1'b1;
    chk("busy_state_dbg", state_dbg, 1);
    read_hilo(h, l);
    chk("busy_old_hi", h, 32'hAAAA);
    chk("busy_old_lo", l, 32'h5555);
    cyc = 1;
    @(negedge clk);
    while (busy && cyc < 200) begin cyc++; @(negedge clk); end
    req = 1'b0;
    chk("req_busy_cycles", cyc, MULT_N);
    read_hilo(h, l);
    chk("req_busy_hi", h, 0);
    chk("req_busy_lo", l, 42);

    // reset during busy cycle 4 of a divide
    set_hilo(32'h11, 32'h22);
    @(negedge clk);
    start = 1'b1; mlu_op = 5'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; mlu_op = 5'd0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("midreset_busy", busy, 0);
    read_hilo(h, l);
    chk("midreset_hi", h, 0);
    chk("midreset_lo", l, 0);
    repeat (15) @(negedge clk);
    chk("midreset_late_busy", busy, 0);
    read_hilo(h, l);
    chk("midreset_late_hi", h, 0);
    chk("midreset_late_lo", l, 0);

    // random commands against the reference model
    set_hilo($urandom, $urandom);
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 11));
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 20));
        1: a = 32'h8000_0000 + 32'($urandom_range(0, 2));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      model(op, a, b, mc);
      issue(op, a, b, 1'b0, cyc);
      read_hilo(h, l);
      chk($sformatf("rand%0d_op%0d_cycles", i, op), cyc, mc);
      chk($sformatf("rand%0d_op%0d_hi", i, op), h, m_hi);
      chk($sformatf("rand%0d_op%0d_lo", i, op), l, m_lo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
